brew_sequencer: RTL

- Timed controller that sequences the coffee machine actuators (heater, water valve, powder doser, mixer) for one drink per START request.
- Sits between the user/selection front end and the actuator drivers, alongside the machine state logic.
- Checks the reservoir, powder and cup sensors before and during a brew, and aborts into a latched fault state with an error code.

---
 rtl/brew_sequencer_if.sv | 29 ++
 rtl/brew_sequencer.sv | 167 ++++++++++++++++
 2 files changed

// File: rtl/brew_sequencer_if.sv
// Front-end/actuator bundle for the brew sequencer.
// The sequencer owns the slave side; the selector/sensor side is the master.
interface brew_sequencer_if;
    logic       start;
    logic [1:0] b;
    logic       sr;
    logic       sp;
    logic       sn;
    logic       temp_ok;
    logic       aq;
    logic       vl;
    logic       pp;
    logic       m;
    logic       busy;
    logic       done;
    logic       err;
    logic [2:0] ecode;
    logic [3:0] st;

    modport master (
        output start, b, sr, sp, sn, temp_ok,
        input  aq, vl, pp, m, busy, done, err, ecode, st
    );

    modport slave (
        input  start, b, sr, sp, sn, temp_ok,
        output aq, vl, pp, m, busy, done, err, ecode, st
    );
endinterface

// File: rtl/brew_sequencer.sv
// Timed actuator sequencer for one drink per START request.
// Sensor checks abort into a latched FAULT holding an error code.
module brew_sequencer #(
    parameter int CW           = 8,
    parameter int HEAT_TIMEOUT = 16,
    parameter int FILL_CYC     = 4,
    parameter int POWDER_CYC   = 2,
    parameter int MIX_CYC      = 6
) (
    input logic             clk,
    input logic             rst_n,
    brew_sequencer_if.slave bus
);

    typedef enum logic [3:0] {
        S_IDLE   = 4'd0,
        S_CHECK  = 4'd1,
        S_HEAT   = 4'd2,
        S_FILL   = 4'd3,
        S_POWDER = 4'd4,
        S_MIX    = 4'd5,
        S_FINISH = 4'd6,
        S_FAULT  = 4'd7
    } state_t;

    localparam logic [2:0] E_WATER  = 3'd1;
    localparam logic [2:0] E_POWDER = 3'd2;
    localparam logic [2:0] E_NOCUP  = 3'd3;
    localparam logic [2:0] E_HEAT   = 3'd4;
    localparam logic [2:0] E_CUPOUT = 3'd5;

    localparam logic [CW-1:0] ONE       = CW'(1);
    localparam logic [CW-1:0] HEAT_LAST = CW'(HEAT_TIMEOUT - 1);
    localparam logic [CW-1:0] MIX_LAST  = CW'(MIX_CYC - 1);

    state_t        state;
    state_t        nxt;
    logic [CW-1:0] cnt;
    logic [1:0]    dose;
    logic [2:0]    ecode_q;
    logic [2:0]    nxt_code;
    logic [CW-1:0] dose_w;
    logic [CW-1:0] fill_last;
    logic [CW-1:0] pow_last;

    assign dose_w    = CW'(dose);
    assign fill_last = dose_w * CW'(FILL_CYC) - ONE;
    assign pow_last  = dose_w * CW'(POWDER_CYC) - ONE;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= S_IDLE;
            cnt     <= '0;
            dose    <= '0;
            ecode_q <= '0;
        end else begin
            state <= nxt;
            cnt   <= (nxt != state) ? '0 : cnt + ONE;
            if (state == S_IDLE && nxt == S_CHECK)
                dose <= bus.b;
            // Code is captured only on entry so it survives the whole fault.
            if (nxt == S_FAULT && state != S_FAULT)
                ecode_q <= nxt_code;
            else if (state == S_FAULT && nxt != S_FAULT)
                ecode_q <= '0;
        end
    end

    always_comb begin
        nxt      = state;
        nxt_code = '0;
        unique case (state)
            S_IDLE: begin
                if (bus.start && bus.b != 2'b00)
                    nxt = S_CHECK;
            end
            S_CHECK: begin
                nxt = S_FAULT;
                if (!bus.sn)      nxt_code = E_NOCUP;
                else if (!bus.sr) nxt_code = E_WATER;
                else if (!bus.sp) nxt_code = E_POWDER;
                else              nxt = S_HEAT;
            end
            S_HEAT: begin
                if (!bus.sn) begin
                    nxt      = S_FAULT;
                    nxt_code = E_CUPOUT;
                end else if (bus.temp_ok) begin
                    nxt = S_FILL;
                end else if (cnt == HEAT_LAST) begin
                    nxt      = S_FAULT;
                    nxt_code = E_HEAT;
                end
            end
            S_FILL: begin
                if (!bus.sn) begin
                    nxt      = S_FAULT;
                    nxt_code = E_CUPOUT;
                end else if (!bus.sr) begin
                    nxt      = S_FAULT;
                    nxt_code = E_WATER;
                end else if (cnt == fill_last) begin
                    nxt = S_POWDER;
                end
            end
            S_POWDER: begin
                if (!bus.sn) begin
                    nxt      = S_FAULT;
                    nxt_code = E_CUPOUT;
                end else if (!bus.sp) begin
                    nxt      = S_FAULT;
                    nxt_code = E_POWDER;
                end else if (cnt == pow_last) begin
                    nxt = S_MIX;
                end
            end
            S_MIX: begin
                if (!bus.sn) begin
                    nxt      = S_FAULT;
                    nxt_code = E_CUPOUT;
                end else if (cnt == MIX_LAST) begin
                    nxt = S_FINISH;
                end
            end
            S_FINISH: nxt = S_IDLE;
            S_FAULT: begin
                if (bus.start)
                    nxt = S_IDLE;
            end
            default: nxt = S_IDLE;
        endcase
    end

    logic aq_d, vl_d, pp_d, m_d, busy_d, done_d, err_d;

    always_comb begin
        aq_d   = 1'b0;
        vl_d   = 1'b0;
        pp_d   = 1'b0;
        m_d    = 1'b0;
        busy_d = 1'b0;
        done_d = 1'b0;
        err_d  = 1'b0;
        unique case (state)
            S_IDLE:   ;
            S_CHECK:  busy_d = 1'b1;
            S_HEAT:   begin busy_d = 1'b1; aq_d = 1'b1; end
            S_FILL:   begin busy_d = 1'b1; vl_d = 1'b1; end
            S_POWDER: begin busy_d = 1'b1; pp_d = 1'b1; end
            S_MIX:    begin busy_d = 1'b1; m_d  = 1'b1; end
            S_FINISH: begin busy_d = 1'b1; done_d = 1'b1; end
            S_FAULT:  err_d = 1'b1;
            default:  ;
        endcase
    end

    assign bus.aq    = aq_d;
    assign bus.vl    = vl_d;
    assign bus.pp    = pp_d;
    assign bus.m     = m_d;
    assign bus.busy  = busy_d;
    assign bus.done  = done_d;
    assign bus.err   = err_d;
    assign bus.ecode = ecode_q;
    assign bus.st    = state;

endmodule
